// File: rtl/weight_loader_if.sv
// Handshake, memory-write and status bundle for weight_loader.
// The master side (controller or testbench) drives start/abort/stream; the slave side is the loader.
interface weight_loader_if;
  logic        start;
  logic        abort;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, abort, s_data, s_valid,
    input  s_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, abort, s_data, s_valid,
    output s_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/weight_loader.sv
// Streams layer-1/layer-2 weight and bias bytes into four memories, one byte per accepted transfer.
// Optional trailer checksum verification is enabled with `define LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int W1_DEPTH = 25088,
  parameter int B1_DEPTH = 32,
  parameter int W2_DEPTH = 320,
  parameter int B2_DEPTH = 10
) (
  input  logic            clk,
  input  logic            rst,
  weight_loader_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LD_W1 = 3'd1;
  localparam logic [2:0] LD_B1 = 3'd2;
  localparam logic [2:0] LD_W2 = 3'd3;
  localparam logic [2:0] LD_B2 = 3'd4;
  localparam logic [2:0] CHECK = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] AFTER_B2 = CHECK;
`else
  localparam logic [2:0] AFTER_B2 = DONE;
`endif

  localparam logic [14:0] W1_LAST = 15'(W1_DEPTH - 1);
  localparam logic [14:0] B1_LAST = 15'(B1_DEPTH - 1);
  localparam logic [14:0] W2_LAST = 15'(W2_DEPTH - 1);
  localparam logic [14:0] B2_LAST = 15'(B2_DEPTH - 1);

  logic [2:0]  state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  wr_sel_q, wr_sel_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        busy;
  logic        ld;
  logic        xfer;
  logic [14:0] region_last;
  logic [1:0]  region_sel;
  logic [2:0]  region_next;

  always_comb begin
    ld   = (state_q == LD_W1) || (state_q == LD_B1) ||
           (state_q == LD_W2) || (state_q == LD_B2);
    busy = ld || (state_q == CHECK);
  end

  assign bus.s_ready = busy && !bus.abort;
  assign xfer        = bus.s_valid && bus.s_ready;
  assign bus.busy    = busy;
  assign bus.done    = (state_q == DONE);
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_sel  = wr_sel_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  always_comb begin
    region_last = W1_LAST;
    region_sel  = 2'd0;
    region_next = LD_B1;
    case (state_q)
      LD_B1: begin region_last = B1_LAST; region_sel = 2'd1; region_next = LD_W2;    end
      LD_W2: begin region_last = W2_LAST; region_sel = 2'd2; region_next = LD_B2;    end
      LD_B2: begin region_last = B2_LAST; region_sel = 2'd3; region_next = AFTER_B2; end
      default: ;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [7:0]  trl_lo_q, trl_lo_d;
  logic        trl_q, trl_d;
  logic        err_q, err_d;
`endif

  // Abort outranks start and any transfer offered in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else if (!busy && bus.start) begin
      state_d = LD_W1;
      cnt_d   = '0;
    end else if (xfer && ld) begin
      wr_en_d   = 1'b1;
      wr_sel_d  = region_sel;
      wr_addr_d = cnt_q;
      wr_data_d = bus.s_data;
      if (cnt_q == region_last) begin
        cnt_d   = '0;
        state_d = region_next;
      end else begin
        cnt_d = cnt_q + 15'd1;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    else if (xfer && (state_q == CHECK) && trl_q) begin
      state_d = DONE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Trailer is low byte then high byte; trl_q marks that the low byte is held.
  always_comb begin
    sum_d    = sum_q;
    trl_lo_d = trl_lo_q;
    trl_d    = trl_q;
    err_d    = err_q;
    if (bus.abort) begin
      trl_d = trl_q;
    end else if (!busy && bus.start) begin
      sum_d = '0;
      trl_d = 1'b0;
      err_d = 1'b0;
    end else if (xfer && ld) begin
      sum_d = sum_q + 16'(bus.s_data);
    end else if (xfer && (state_q == CHECK)) begin
      if (!trl_q) begin
        trl_lo_d = bus.s_data;
        trl_d    = 1'b1;
      end else begin
        err_d = ({bus.s_data, trl_lo_q} != sum_q);
        trl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      trl_lo_q <= '0;
      trl_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      trl_lo_q <= trl_lo_d;
      trl_q    <= trl_d;
      err_q    <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: control-vector table, full-stream scoreboard runs,
// boundary bubbles, abort, ignored start, and asynchronous reset mid-load.
module tb_weight_loader;

  localparam int unsigned W1 = 25088;
  localparam int unsigned B1 = 32;
  localparam int unsigned W2 = 320;
  localparam int unsigned B2 = 10;
  localparam int unsigned TOTAL = W1 + B1 + W2 + B2;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk;
  logic rst;
  weight_loader_if bus();

  weight_loader #(
    .W1_DEPTH(W1),
    .B1_DEPTH(B1),
    .W2_DEPTH(W2),
    .B2_DEPTH(B2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic       st;
    logic       ab;
    logic       v;
    logic [7:0] d;
    logic       exp_rdy;
    logic       exp_busy;
    logic       exp_wen;
    logic [14:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr_cnt = 0;
  bit          mon_en = 1'b0;
  wr_t         exp_q[$];

  // Reference model state
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  int unsigned m_idx  = 0;
  logic [15:0] m_sum  = '0;
  int unsigned m_tr   = 0;
  logic [7:0]  m_lo   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t expect_wr(input int unsigned idx, input logic [7:0] d);
    wr_t e;
    e.data = d;
    if (idx < W1) begin
      e.sel = 2'd0; e.addr = 15'(idx);
    end else if (idx < W1 + B1) begin
      e.sel = 2'd1; e.addr = 15'(idx - W1);
    end else if (idx < W1 + B1 + W2) begin
      e.sel = 2'd2; e.addr = 15'(idx - W1 - B1);
    end else begin
      e.sel = 2'd3; e.addr = 15'(idx - W1 - B1 - W2);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wr_en", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_sel", 32'(bus.wr_sel), 32'(e.sel));
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        wr_cnt++;
      end
    end
  end

  // One cycle: drive inputs, check s_ready, update model, clock, check status.
  task automatic step(input logic v, input logic [7:0] d, input logic ab, input logic st);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.abort   = ab;
    bus.start   = st;
    #1;
    chk("s_ready", 32'(bus.s_ready), 32'(m_busy && !ab));
    if (ab) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (st && !m_busy) begin
      m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
      m_idx = 0; m_sum = '0; m_tr = 0;
    end else if (m_busy && v) begin
      if (m_idx < TOTAL) begin
        exp_q.push_back(expect_wr(m_idx, d));
        m_sum = m_sum + 16'(d);
        m_idx++;
        if (m_idx == TOTAL && !CK) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (m_tr == 0) begin
        m_lo = d;
        m_tr = 1;
      end else begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_err  = ({d, m_lo} != m_sum);
      end
    end
    @(posedge clk);
    #1;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("err", 32'(bus.err), 32'(m_err));
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
    chk({tag, "_wr_sel"},  32'(bus.wr_sel),  32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_err"},     32'(bus.err),     32'd0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[13];
    int unsigned n;
    logic [7:0]  d;
    logic        v;
    logic        tog;
    bit          w2_started;

    bus.start = 1'b0; bus.abort = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    //          st    ab    v     d      rdy   busy  wen   addr    data
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 15'd0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 15'd0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 15'd0, 8'hA5};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 15'd0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 15'd1, 8'h3C};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 15'd2, 8'h77};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 15'd0, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 15'd0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 15'd0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 15'd0, 8'h11};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 15'd0, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 15'd0, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 15'd0, 8'h00};

    for (int i = 0; i < 13; i++) begin
      bus.start = vecs[i].st; bus.abort = vecs[i].ab;
      bus.s_valid = vecs[i].v; bus.s_data = vecs[i].d;
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(bus.s_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i),  32'(bus.done),  32'd0);
      chk($sformatf("vec%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].exp_wen));
      if (vecs[i].exp_wen) begin
        chk($sformatf("vec%0d_wr_sel", i),  32'(bus.wr_sel),  32'd0);
        chk($sformatf("vec%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].exp_data));
      end
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.s_valid = 1'b0;
    mon_en = 1'b1;

    // Full load, s_valid constant high, all payload bytes 0x01 (sum 0x636A).
    wr_cnt = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n = 0;
    while (m_busy && n < 40000) begin
      d = (m_idx < TOTAL) ? 8'h01 : ((m_tr == 0) ? 8'h6A : 8'h63);
      step(1'b1, d, 1'b0, 1'b0);
      n++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("load1_write_count", wr_cnt, TOTAL);
    chk("load1_queue_empty", exp_q.size(), 0);
    chk("load1_done", 32'(bus.done), 32'd1);
    chk("load1_err", 32'(bus.err), 32'd0);

    // Random data/bubbles; 1/0 toggling across w1->b1; start pulse in LD_W2; zero trailer.
    wr_cnt = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n = 0; tog = 1'b1; w2_started = 1'b0;
    while (m_busy && n < 60000) begin
      d = 8'($urandom);
      if (m_idx >= W1 - 4 && m_idx <= W1 + 4) begin
        v = tog;
        tog = ~tog;
      end else begin
        v = ($urandom_range(7) != 0);
      end
      if (m_idx >= TOTAL) d = 8'h00;
      if (!w2_started && m_idx == W1 + B1 + 5) begin
        w2_started = 1'b1;
        step(v, d, 1'b0, 1'b1);
      end else begin
        step(v, d, 1'b0, 1'b0);
      end
      n++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("load2_write_count", wr_cnt, TOTAL);
    chk("load2_queue_empty", exp_q.size(), 0);
    chk("load2_done", 32'(bus.done), 32'd1);
    chk("load2_err", 32'(bus.err), 32'(CK && (m_sum != 16'h0000)));

    // Abort while byte 100 is offered; then restart at (0,0).
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    step(1'b1, 8'hEF, 1'b0, 1'b0);
    chk("abort_no_write", exp_q.size(), 0);
    wr_cnt = 0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("restart_one_write", wr_cnt, 1);

    // Reset asynchronously while in LD_B1.
    n = 0;
    while (m_idx < W1 + 10 && n < 30000) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      n++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_reset_queue_empty", exp_q.size(), 0);
    bus.s_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_idx = 0; m_sum = '0; m_tr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("post_reset_no_write", wr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
